// File: rtl/day08_pkg.sv
// day08_pkg: shared types for pair_batch_scheduler and its point store.
//   coord_t  - one coordinate
//   point_t  - DIMENSIONS_DEFAULT coordinates, element 0 in the low bits
//   state_e  - scheduler phase (load points, emit batches, finished)
// Modules that carry point_t must be built with COORD_BIT_WIDTH / DIMENSIONS equal to the
// defaults below, since the package types are not parameterisable.
package day08_pkg;

  localparam int unsigned COORD_WIDTH_DEFAULT = 12;
  localparam int unsigned DIMENSIONS_DEFAULT  = 3;

  typedef logic [COORD_WIDTH_DEFAULT-1:0] coord_t;
  typedef coord_t [DIMENSIONS_DEFAULT-1:0] point_t;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StEmit = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/point_store.sv
// point_store: point memory with one write port and BATCH_SIZE read ports that return the
// points at consecutive indices rd_base, rd_base+1, ... together with a flag telling whether
// each index lies below rd_limit. Out-of-range slots read as zero.
//   clk         - clock
//   wr_en       - write wr_data at wr_addr on the rising edge
//   wr_addr     - write index
//   wr_data     - point to store
//   rd_base     - index of read slot 0
//   rd_limit    - number of valid points (slot s valid iff rd_base+s < rd_limit)
//   rd_data     - point per read slot
//   rd_in_range - per-slot valid flag
module point_store
  import day08_pkg::*;
#(
  parameter int unsigned MAX_NODE_COUNT = 2000,
  parameter int unsigned BATCH_SIZE     = 16,
  parameter int unsigned ADDR_WIDTH     = $clog2(MAX_NODE_COUNT),
  parameter int unsigned SPAN_WIDTH     = ADDR_WIDTH + 1
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  point_t                        wr_data,
  input  logic [SPAN_WIDTH-1:0]         rd_base,
  input  logic [SPAN_WIDTH-1:0]         rd_limit,
  output point_t [BATCH_SIZE-1:0]       rd_data,
  output logic [BATCH_SIZE-1:0]         rd_in_range
);

  // Wide enough that rd_base + (BATCH_SIZE-1) never wraps.
  localparam int unsigned SumWidth = SPAN_WIDTH + $clog2(BATCH_SIZE) + 1;

  point_t mem [MAX_NODE_COUNT];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar s = 0; s < BATCH_SIZE; s++) begin : g_rd
    logic [SumWidth-1:0]   idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  fwd;

    assign idx            = SumWidth'(rd_base) + SumWidth'(s);
    assign addr           = idx[ADDR_WIDTH-1:0];
    assign rd_in_range[s] = idx < SumWidth'(rd_limit);
    // The final point is written on the same edge that loads the first batch, so a write
    // to the slot being read is forwarded.
    assign fwd            = wr_en && (wr_addr == addr);
    assign rd_data[s]     = !rd_in_range[s] ? '0 : (fwd ? wr_data : mem[addr]);
  end

endmodule

// File: rtl/pair_batch_scheduler.sv
// pair_batch_scheduler: loads a stream of points, then emits, for every reference point i,
// the points i..N-1 in ascending order in batches of BATCH_SIZE slots. Slot 0 of the first
// batch of each line is point i itself.
//   clk, rst          - clock, synchronous active-high reset
//   pt_valid/pt_ready - point handshake (ready only while loading)
//   pt_coords         - point coordinates
//   pt_last           - final point of the stream
//   out_ready         - downstream ready; a batch is consumed when |batch_valid && out_ready
//   batch_coords      - per-slot coordinates (zero in invalid slots)
//   batch_indices     - per-slot point index (zero in invalid slots)
//   batch_valid       - per-slot valid
//   batch_line_end    - batch holds index N-1
//   batch_stream_end  - last batch of the last line
//   busy              - not loading
//   perf_stall_cycles - only with PAIR_BATCH_SCHEDULER_PERF_EN: saturating count of cycles
//                       a batch was held because out_ready was low
module pair_batch_scheduler
  import day08_pkg::*;
#(
  parameter int unsigned MAX_NODE_COUNT  = 2000,
  parameter int unsigned COORD_BIT_WIDTH = COORD_WIDTH_DEFAULT,
  parameter int unsigned DIMENSIONS      = DIMENSIONS_DEFAULT,
  parameter int unsigned BATCH_SIZE      = 16,
  localparam int unsigned INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT)
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic                                                        pt_valid,
  output logic                                                        pt_ready,
  input  logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]                  pt_coords,
  input  logic                                                        pt_last,
  input  logic                                                        out_ready,
  output logic [BATCH_SIZE-1:0][DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]  batch_coords,
  output logic [BATCH_SIZE-1:0][INDEX_BIT_WIDTH-1:0]                  batch_indices,
  output logic [BATCH_SIZE-1:0]                                       batch_valid,
  output logic                                                        batch_line_end,
  output logic                                                        batch_stream_end,
  output logic                                                        busy
`ifdef PAIR_BATCH_SCHEDULER_PERF_EN
  ,
  output logic [31:0]                                                 perf_stall_cycles
`endif
);

  // Counts up to MAX_NODE_COUNT inclusive, hence one bit more than an index.
  localparam int unsigned CW       = INDEX_BIT_WIDTH + 1;
  localparam int unsigned SumWidth = CW + $clog2(BATCH_SIZE) + 1;

  state_e          state_q;
  logic [CW-1:0]   count_q;  // points stored; equals N once loading ends
  logic [CW-1:0]   line_q;   // reference point of the next batch to load
  logic [CW-1:0]   base_q;   // index in slot 0 of the next batch to load

  logic            wr_en;
  logic            accept_last;
  logic            consume;
  logic            load_en;
  logic            finish_en;

  logic [CW-1:0]   ld_base;
  logic [CW-1:0]   ld_line;
  logic [CW-1:0]   ld_limit;
  logic            ld_line_end;
  logic            ld_stream_end;
  logic [CW-1:0]   nxt_line;
  logic [CW-1:0]   nxt_base;

  point_t [BATCH_SIZE-1:0]                    rd_data;
  logic [BATCH_SIZE-1:0]                      ld_in_range;
  logic [BATCH_SIZE-1:0][INDEX_BIT_WIDTH-1:0] ld_indices;

  assign pt_ready = (state_q == StLoad);
  assign busy     = (state_q != StLoad);

  assign wr_en       = (state_q == StLoad) && pt_valid;
  // The last storage slot closes the stream even without pt_last.
  assign accept_last = pt_last || (count_q == CW'(MAX_NODE_COUNT - 1));
  assign consume     = (state_q == StEmit) && (|batch_valid) && out_ready;
  assign load_en     = (wr_en && accept_last) || (consume && !batch_stream_end);
  assign finish_en   = consume && batch_stream_end;

  // While loading, the first batch (line 0, base 0) is built against N = count+1.
  always_comb begin
    if (state_q == StLoad) begin
      ld_base  = '0;
      ld_line  = '0;
      ld_limit = count_q + CW'(1);
    end else begin
      ld_base  = base_q;
      ld_line  = line_q;
      ld_limit = count_q;
    end
  end

  always_comb begin
    ld_line_end   = (SumWidth'(ld_base) + SumWidth'(BATCH_SIZE)) >= SumWidth'(ld_limit);
    ld_stream_end = ld_line_end && (ld_line == ld_limit - CW'(1));
    nxt_line      = ld_line_end ? ld_line + CW'(1) : ld_line;
    nxt_base      = ld_line_end ? ld_line + CW'(1) : ld_base + CW'(BATCH_SIZE);
  end

  for (genvar s = 0; s < BATCH_SIZE; s++) begin : g_slot
    // In range implies ld_base + s < N <= MAX_NODE_COUNT, so CW bits cannot wrap.
    assign ld_indices[s] = ld_in_range[s] ? INDEX_BIT_WIDTH'(ld_base + CW'(s)) : '0;
  end

  point_store #(
    .MAX_NODE_COUNT (MAX_NODE_COUNT),
    .BATCH_SIZE     (BATCH_SIZE),
    .ADDR_WIDTH     (INDEX_BIT_WIDTH),
    .SPAN_WIDTH     (CW)
  ) u_point_store (
    .clk         (clk),
    .wr_en       (wr_en),
    .wr_addr     (count_q[INDEX_BIT_WIDTH-1:0]),
    .wr_data     (pt_coords),
    .rd_base     (ld_base),
    .rd_limit    (ld_limit),
    .rd_data     (rd_data),
    .rd_in_range (ld_in_range)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StLoad;
      count_q          <= '0;
      line_q           <= '0;
      base_q           <= '0;
      batch_coords     <= '0;
      batch_indices    <= '0;
      batch_valid      <= '0;
      batch_line_end   <= 1'b0;
      batch_stream_end <= 1'b0;
    end else begin
      if (load_en) begin
        batch_coords     <= rd_data;
        batch_indices    <= ld_indices;
        batch_valid      <= ld_in_range;
        batch_line_end   <= ld_line_end;
        batch_stream_end <= ld_stream_end;
        line_q           <= nxt_line;
        base_q           <= nxt_base;
      end else if (finish_en) begin
        batch_coords     <= '0;
        batch_indices    <= '0;
        batch_valid      <= '0;
        batch_line_end   <= 1'b0;
        batch_stream_end <= 1'b0;
      end

      unique case (state_q)
        StLoad: begin
          if (pt_valid) begin
            count_q <= count_q + CW'(1);
            if (accept_last) begin
              state_q <= StEmit;
            end
          end
        end
        StEmit: begin
          if (finish_en) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

`ifdef PAIR_BATCH_SCHEDULER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
    end else if ((state_q == StEmit) && (|batch_valid) && !out_ready &&
                 (perf_stall_cycles != '1)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pair_batch_scheduler.sv
// Self-checking bench for pair_batch_scheduler: random points and random downstream
// back-pressure, checked batch by batch against an expected batch list built from the
// line/batch rules (one queue entry per batch, in emission order).
module tb_pair_batch_scheduler;

  localparam int unsigned MAXN = 24;
  localparam int unsigned CB   = 12;
  localparam int unsigned DIM  = 3;
  localparam int unsigned BS   = 16;
  localparam int unsigned IW   = $clog2(MAXN);

  typedef logic [DIM-1:0][CB-1:0] pt_t;

  typedef struct {
    logic [BS-1:0]                   valid;
    logic                            le;
    logic                            se;
    logic [BS-1:0][IW-1:0]           idx;
    logic [BS-1:0][DIM-1:0][CB-1:0]  crd;
    int                              line;
  } batch_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pt_valid = 1'b0;
  logic pt_last = 1'b0;
  logic out_ready = 1'b0;
  pt_t  pt_coords;
  logic pt_ready;
  logic [BS-1:0][DIM-1:0][CB-1:0] batch_coords;
  logic [BS-1:0][IW-1:0]          batch_indices;
  logic [BS-1:0]                  batch_valid;
  logic batch_line_end;
  logic batch_stream_end;
  logic busy;
`ifdef PAIR_BATCH_SCHEDULER_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int     n_cmp;
  int     n_err;
  pt_t    pts [MAXN];
  batch_t exp_q [$];

  always #5 clk = ~clk;

  pair_batch_scheduler #(
    .MAX_NODE_COUNT  (MAXN),
    .COORD_BIT_WIDTH (CB),
    .DIMENSIONS      (DIM),
    .BATCH_SIZE      (BS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pt_valid         (pt_valid),
    .pt_ready         (pt_ready),
    .pt_coords        (pt_coords),
    .pt_last          (pt_last),
    .out_ready        (out_ready),
    .batch_coords     (batch_coords),
    .batch_indices    (batch_indices),
    .batch_valid      (batch_valid),
    .batch_line_end   (batch_line_end),
    .batch_stream_end (batch_stream_end),
    .busy             (busy)
`ifdef PAIR_BATCH_SCHEDULER_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line i covers i..n-1; batches step by BS from i.
  task automatic build_model(input int n);
    batch_t e;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int b = i; b < n; b += int'(BS)) begin
        e.valid = '0;
        e.idx   = '0;
        e.crd   = '0;
        e.line  = i;
        for (int s = 0; s < int'(BS); s++) begin
          if (b + s < n) begin
            e.valid[s] = 1'b1;
            e.idx[s]   = IW'(b + s);
            e.crd[s]   = pts[b + s];
          end
        end
        e.le = (b + int'(BS) >= n);
        e.se = e.le && (i == n - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pt_valid = 1'b0; pt_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 640'(batch_valid), 640'(0));
    check("rst_flags", 640'({batch_line_end, batch_stream_end}), 640'(0));
    check("rst_ready", 640'(pt_ready), 640'(1));
    check("rst_busy", 640'(busy), 640'(0));
  endtask

  // mode 0: out_ready always 1; 1: random; 2: pattern 1,0,0,1,1,...
  task automatic run_stream(input int n, input bit use_last, input int mode, input int abort_line);
    int     ptr;
    int     cyc;
    int     stalls;
    bit     r;
    batch_t e;
    do_reset();
    for (int k = 0; k < n; k++) pts[k] = pt_t'({$urandom, $urandom});
    build_model(n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        pt_valid = 1'b0;
        @(negedge clk);
      end
      pt_valid  = 1'b1;
      pt_coords = pts[k];
      pt_last   = use_last && (k == n - 1);
      check("load_ready", 640'(pt_ready), 640'(1));
      check("load_idle", 640'(batch_valid), 640'(0));
      @(negedge clk);
    end
    pt_valid = 1'b0; pt_last = 1'b0; pt_coords = '0;
    check("emit_ready", 640'(pt_ready), 640'(0));
    check("emit_busy", 640'(busy), 640'(1));
    ptr = 0; cyc = 0; stalls = 0;
    while (ptr < exp_q.size() && cyc < 2000) begin
      e = exp_q[ptr];
      check("b_valid", 640'(batch_valid), 640'(e.valid));
      check("b_idx", 640'(batch_indices), 640'(e.idx));
      check("b_crd", 640'(batch_coords), 640'(e.crd));
      check("b_line_end", 640'(batch_line_end), 640'(e.le));
      check("b_stream_end", 640'(batch_stream_end), 640'(e.se));
      if (abort_line >= 0 && e.line == abort_line) begin
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("abort_valid", 640'(batch_valid), 640'(0));
        check("abort_ready", 640'(pt_ready), 640'(1));
        check("abort_busy", 640'(busy), 640'(0));
        rst = 1'b0; out_ready = 1'b0;
        return;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: r = !(cyc == 1 || cyc == 2);
      endcase
      out_ready = r;
      if (r) ptr++;
      else stalls++;
      @(negedge clk);
      cyc++;
    end
    check("emit_count", 640'(ptr), 640'(exp_q.size()));
`ifdef PAIR_BATCH_SCHEDULER_PERF_EN
    check("perf_stalls", 640'(perf_stall_cycles), 640'(stalls));
`endif
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      check("done_valid", 640'(batch_valid), 640'(0));
      check("done_flags", 640'({batch_line_end, batch_stream_end}), 640'(0));
      check("done_ready", 640'(pt_ready), 640'(0));
      check("done_busy", 640'(busy), 640'(1));
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    pt_coords = '0;
    repeat (2) @(negedge clk);
    run_stream(3, 1'b1, 0, -1);
    run_stream(20, 1'b1, 0, -1);
    run_stream(3, 1'b1, 2, -1);
    run_stream(int'(MAXN), 1'b0, 1, -1);
    run_stream(1, 1'b1, 0, -1);
    run_stream(5, 1'b1, 1, 2);
    run_stream(2, 1'b1, 1, -1);
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, MAXN));
      run_stream(n, (n != int'(MAXN)) || ($urandom_range(0, 1) == 1), 1, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pair_batch_scheduler.md
PAIR_BATCH_SCHEDULER -- requirements
Module: pair_batch_scheduler

Interface
REQ-001 SHALL have parameter MAX_NODE_COUNT, default 2000: point storage capacity.
REQ-002 SHALL have parameter COORD_BIT_WIDTH, default 12: bits per coordinate.
REQ-003 SHALL have parameter DIMENSIONS, default 3: coordinates per point.
REQ-004 SHALL have parameter BATCH_SIZE, default 16: points per emitted batch; INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT) is local.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: pt_valid  in  1  point offered; pt_ready  out  1  point accepted when both high.
REQ-007 SHALL have ports: pt_coords  in  [COORD_BIT_WIDTH] x DIMENSIONS  point coordinates; pt_last  in  1  final point of stream.
REQ-008 SHALL have ports: out_ready  in  1  downstream ready (driven by consumer's in_ready).
REQ-009 SHALL have ports: batch_coords  out  [COORD_BIT_WIDTH] x BATCH_SIZE x DIMENSIONS; batch_indices  out  [INDEX_BIT_WIDTH] x BATCH_SIZE.
REQ-010 SHALL have ports: batch_valid  out  BATCH_SIZE  per-slot valid; batch_line_end  out  1; batch_stream_end  out  1; busy  out  1  not in LOAD.

Function
REQ-011 SHALL implement states LOAD, EMIT, DONE; reset enters LOAD.
REQ-012 In LOAD, pt_ready SHALL be 1 and each accepted point SHALL be stored at index count, count incrementing by 1.
REQ-013 Point accepted at index MAX_NODE_COUNT-1 SHALL be treated as pt_last regardless of pt_last input.
REQ-014 Acceptance of the last point SHALL move LOAD->EMIT with N = count+1, line i=0, offset 0; pt_ready SHALL be 0 outside LOAD.
REQ-015 Line i SHALL cover indices i..N-1 in ascending order; batch k of line i SHALL carry slot s = index i+k*BATCH_SIZE+s, batch_valid[s]=1 iff that index < N.
REQ-016 Slot 0 of the first batch of every line SHALL be point i itself (reference point for the consumer).
REQ-017 batch_line_end SHALL be 1 on the batch containing index N-1; batch_stream_end SHALL be 1 only on that batch of line N-1.
REQ-018 Outputs SHALL be registered; first batch SHALL be presented the cycle after the last point is accepted.
REQ-019 A batch SHALL be consumed when |batch_valid and out_ready; all batch outputs SHALL hold stable while not consumed.
REQ-020 On consumption the next batch SHALL appear the following cycle (one batch per cycle at full throughput); after the stream_end batch, state SHALL go DONE with batch_valid=0.
REQ-021 Invalid slots SHALL drive coords and indices 0.
REQ-022 DONE SHALL persist until rst.
REQ-023 N=1 SHALL emit exactly one batch: slot 0 valid, index 0, line_end=1, stream_end=1.

Reset
REQ-024 rst SHALL return to LOAD from any state, clearing count, line/offset counters, batch_valid, batch_line_end, batch_stream_end, busy; stored points need not be cleared.
REQ-025 rst asserted while a batch is held SHALL drop batch_valid next cycle without completing the handshake.

Configuration
REQ-026 With PAIR_BATCH_SCHEDULER_PERF_EN defined, SHALL add output perf_stall_cycles [32] counting cycles in EMIT with |batch_valid and !out_ready, cleared by rst, saturating at all-ones.
REQ-027 Without PAIR_BATCH_SCHEDULER_PERF_EN, port and counter SHALL be absent; behaviour otherwise identical.

Structure
REQ-028 Package day08_pkg SHALL hold coord_t, point_t (DIMENSIONS x coord_t) and the state enum.
REQ-029 Storage SHALL be sub-module point_store: one write port, BATCH_SIZE consecutive-index read ports returning point_t and in-range flags.

Verification
REQ-030 N=3, BATCH_SIZE=16, out_ready=1 -> batches idx {0,1,2},{1,2},{2}; line_end on each; stream_end only on third.
REQ-031 N=20, BATCH_SIZE=16 -> line 0: idx 0..15 then 16..19 (valid 0x000F, line_end); line 19: single batch idx 19, stream_end.
REQ-032 out_ready toggled 1,0,0,1 in EMIT -> outputs frozen during low cycles; no batch skipped or duplicated; PERF_EN build counts 2 stalls.
REQ-033 MAX_NODE_COUNT=4, pt_last never asserted -> 4th point ends LOAD, pt_ready=0, emission of 4 lines follows.
REQ-034 Single point (N=1) -> one batch valid=0x0001, index 0, line_end=stream_end=1, then DONE.
REQ-035 rst pulsed mid-EMIT on line 2 -> next cycle batch_valid=0, pt_ready=1; fresh 2-point stream emits correctly.
